topview_inverse: RTL

- Maps a line segment from top-view (bird's-eye) pixel coordinates back into camera-image pixel coordinates.
- This is the inverse of the forward perspective-to-topview transform. Planning logic uses it to project top-view lane/route segments onto the camera frame for overlay and ROI selection.
- Iterative: one shared restoring divider, fixed latency, valid/ready handshake on both sides.

---
 rtl/topview_inverse.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/topview_inverse.sv
// rtl/topview_inverse.sv - maps a top-view segment back into camera-image pixel coordinates
// One shared 32-step restoring divider serves u and v of both endpoints; latency is fixed.
module topview_inverse #(
    parameter int IN_WIDTH   = 640,
    parameter int IN_HEIGHT  = 480,
    parameter int OUT_WIDTH  = 180,
    parameter int OUT_HEIGHT = 480,
    parameter int SCALE      = 1,
    parameter int HC         = 5,
    parameter int DVC        = 45,
    parameter int F          = 210,
    parameter int CX         = IN_WIDTH / 2,
    parameter int CY         = IN_HEIGHT / 2,
    parameter int CXP        = OUT_WIDTH / 2,
    parameter int CYP        = OUT_HEIGHT / 2,
    parameter int COS_Q      = 61584,
    parameter int SIN_Q      = 22415
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic signed [31:0]            in_start_h,
    input  logic signed [31:0]            in_start_v,
    input  logic signed [31:0]            in_end_h,
    input  logic signed [31:0]            in_end_v,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [$clog2(IN_WIDTH):0]     out_start_h,
    output logic [$clog2(IN_HEIGHT):0]    out_start_v,
    output logic [$clog2(IN_WIDTH):0]     out_end_h,
    output logic [$clog2(IN_HEIGHT):0]    out_end_v,
    output logic                          out_clip,
    output logic                          out_behind
);

    localparam int WH = $clog2(IN_WIDTH) + 1;
    localparam int WV = $clog2(IN_HEIGHT) + 1;

    localparam logic signed [47:0] L_SCALE  = 48'(SCALE);
    localparam logic signed [47:0] L_DVC    = 48'(DVC);
    localparam logic signed [47:0] L_F      = 48'(F);
    localparam logic signed [47:0] L_COS    = 48'(COS_Q);
    localparam logic signed [47:0] L_SIN    = 48'(SIN_Q);
    localparam logic signed [47:0] L_CXP    = 48'(CXP);
    localparam logic signed [47:0] L_CYP    = 48'(CYP);
    localparam logic signed [47:0] L_HC_SIN = 48'(HC) * 48'(SIN_Q);
    localparam logic signed [47:0] L_HC_COS = 48'(HC) * 48'(COS_Q);
    localparam logic signed [33:0] L_CX     = 34'(CX);
    localparam logic signed [33:0] L_CY     = 34'(CY);
    localparam logic signed [33:0] L_UMAX   = 34'(IN_WIDTH - 1);
    localparam logic signed [33:0] L_VMAX   = 34'(IN_HEIGHT - 1);

    typedef enum logic [2:0] {S_IDLE, S_CALC, S_DIVU, S_DIVV, S_FIN, S_OUT} state_t;

    state_t                r_state;
    state_t                w_next;

    logic signed [31:0]    r_sh, r_sv, r_eh, r_ev;
    logic                  r_pt;
    logic signed [47:0]    r_xg, r_zc, r_yc;
    logic [4:0]            r_cnt;
    logic [48:0]           r_rem;
    logic [30:0]           r_quo;
    logic signed [32:0]    r_qu;
    logic [WH-1:0]         r_s_h, r_e_h, r_o_sh, r_o_eh;
    logic [WV-1:0]         r_s_v, r_e_v, r_o_sv, r_o_ev;
    logic                  r_clip, r_behind, r_o_clip, r_o_behind;

    logic signed [47:0]    w_px48, w_py48, w_xg, w_zg, w_zc, w_yc, w_num;
    logic                  w_num_neg;
    logic [47:0]           w_num_abs, w_den;
    logic [31:0]           w_num32, w_quo_nxt;
    logic [48:0]           w_trial, w_rem_nxt;
    logic                  w_ge;
    logic signed [32:0]    w_q_signed;
    logic signed [33:0]    w_u_raw, w_v_raw;
    logic                  w_u_lo, w_u_hi, w_v_lo, w_v_hi, w_behind, w_pt_clip;
    logic [WH-1:0]         w_u_fin;
    logic [WV-1:0]         w_v_fin;

    // Ground-plane point and camera-frame depth/height for the endpoint in progress
    assign w_px48 = r_pt ? 48'(r_eh) : 48'(r_sh);
    assign w_py48 = r_pt ? 48'(r_ev) : 48'(r_sv);
    assign w_xg   = (w_px48 - L_CXP) * L_SCALE;
    assign w_zg   = (L_CYP - w_py48) * L_SCALE + L_DVC;
    assign w_zc   = w_zg * L_COS + L_HC_SIN;
    assign w_yc   = L_HC_COS - w_zg * L_SIN;

    assign w_num     = (r_state == S_DIVV) ? (L_F * r_yc) : ((L_F * r_xg) <<< 16);
    assign w_num_neg = w_num[47];
    assign w_num_abs = w_num_neg ? -w_num : w_num;
    assign w_num32   = (|w_num_abs[47:32]) ? 32'hFFFF_FFFF : w_num_abs[31:0];
    assign w_den     = r_zc[47] ? -r_zc : r_zc;

    assign w_trial    = (r_rem << 1) | {48'd0, w_num32[5'd31 - r_cnt]};
    assign w_ge       = w_trial >= {1'b0, w_den};
    assign w_rem_nxt  = w_ge ? (w_trial - {1'b0, w_den}) : w_trial;
    assign w_quo_nxt  = {r_quo, w_ge};
    assign w_q_signed = w_num_neg ? -$signed({1'b0, w_quo_nxt}) : $signed({1'b0, w_quo_nxt});

    // Finalisation for the endpoint: v is taken straight from the last divider step
    assign w_u_raw   = L_CX + 34'(r_qu);
    assign w_v_raw   = L_CY + 34'(w_q_signed);
    assign w_u_lo    = w_u_raw < 34'sd0;
    assign w_u_hi    = w_u_raw > L_UMAX;
    assign w_v_lo    = w_v_raw < 34'sd0;
    assign w_v_hi    = w_v_raw > L_VMAX;
    assign w_behind  = r_zc[47] | (r_zc == 48'sd0);
    assign w_pt_clip = ~w_behind & (w_u_lo | w_u_hi | w_v_lo | w_v_hi);
    assign w_u_fin   = (w_behind | w_u_lo) ? '0 : (w_u_hi ? L_UMAX[WH-1:0] : w_u_raw[WH-1:0]);
    assign w_v_fin   = (w_behind | w_v_lo) ? '0 : (w_v_hi ? L_VMAX[WV-1:0] : w_v_raw[WV-1:0]);

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (in_valid) w_next = S_CALC;
            S_CALC: w_next = S_DIVU;
            S_DIVU: if (r_cnt == 5'd31) w_next = S_DIVV;
            S_DIVV: if (r_cnt == 5'd31) w_next = r_pt ? S_FIN : S_CALC;
            S_FIN:  w_next = S_OUT;
            S_OUT:  if (out_ready) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sh <= '0; r_sv <= '0; r_eh <= '0; r_ev <= '0;
            r_pt <= 1'b0;
            r_xg <= '0; r_zc <= '0; r_yc <= '0;
            r_cnt <= '0; r_rem <= '0; r_quo <= '0; r_qu <= '0;
            r_s_h <= '0; r_s_v <= '0; r_e_h <= '0; r_e_v <= '0;
            r_clip <= 1'b0; r_behind <= 1'b0;
            r_o_sh <= '0; r_o_sv <= '0; r_o_eh <= '0; r_o_ev <= '0;
            r_o_clip <= 1'b0; r_o_behind <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: if (in_valid) begin
                    r_sh <= in_start_h; r_sv <= in_start_v;
                    r_eh <= in_end_h;   r_ev <= in_end_v;
                    r_pt <= 1'b0; r_clip <= 1'b0; r_behind <= 1'b0;
                end
                S_CALC: begin
                    r_xg <= w_xg; r_zc <= w_zc; r_yc <= w_yc;
                    r_cnt <= '0; r_rem <= '0;
                end
                S_DIVU, S_DIVV: begin
                    r_rem <= w_rem_nxt;
                    r_quo <= w_quo_nxt[30:0];
                    r_cnt <= r_cnt + 5'd1;
                    if (r_cnt == 5'd31) begin
                        r_rem <= '0;
                        if (r_state == S_DIVU) begin
                            r_qu <= w_q_signed;
                        end else begin
                            if (r_pt) begin r_e_h <= w_u_fin; r_e_v <= w_v_fin; end
                            else      begin r_s_h <= w_u_fin; r_s_v <= w_v_fin; end
                            r_clip   <= r_clip | w_pt_clip;
                            r_behind <= r_behind | w_behind;
                            r_pt     <= 1'b1;
                        end
                    end
                end
                S_FIN: begin
                    r_o_sh <= r_s_h; r_o_sv <= r_s_v;
                    r_o_eh <= r_e_h; r_o_ev <= r_e_v;
                    r_o_clip <= r_clip; r_o_behind <= r_behind;
                end
                default: ;
            endcase
        end
    end

    assign in_ready    = (r_state == S_IDLE);
    assign out_valid   = (r_state == S_OUT);
    assign out_start_h = r_o_sh;
    assign out_start_v = r_o_sv;
    assign out_end_h   = r_o_eh;
    assign out_end_v   = r_o_ev;
    assign out_clip    = r_o_clip;
    assign out_behind  = r_o_behind;

endmodule
